// File: rtl/bram_rw_fill.sv
// -----------------------------------------------------------------------------
// bram_rw_fill
//
// Single-clock block RAM with one synchronous write port, one registered read
// port and a fill engine that rewrites every word to INIT_VAL on request.
// Intended for small preloadable tables that are rewritten or cleared at
// runtime.
//
// Ports:
//   clk         system clock, all logic on the rising edge
//   rst_n       asynchronous active-low reset (does not touch the array)
//   wr_en       write request
//   wr_addr     write address
//   wr_data     write data
//   rd_en       read request
//   rd_addr     read address
//   data_out    read data, holds its last value between reads
//   valid_out   one-cycle pulse marking data_out valid
//   addr_err    sticky flag, set when an out-of-range address is presented
//   err_clr     clears addr_err (a same-cycle new error wins)
//   fill_start  starts the fill engine
//   busy        fill engine active; user requests are ignored while high
//
// Parameters:
//   DATA_W    word width
//   DEPTH     number of words, need not be a power of two
//   ADDR_W    address width, 2**ADDR_W >= DEPTH
//   INIT_VAL  power-up contents and fill value
//   READ_LAT  1 or 2; 2 adds an output register stage
// -----------------------------------------------------------------------------
module bram_rw_fill #(
    parameter int                DATA_W   = 8,
    parameter int                DEPTH    = 9,
    parameter int                ADDR_W   = 4,
    parameter logic [DATA_W-1:0] INIT_VAL = DATA_W'(1),
    parameter int                READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              addr_err,
    input  logic              err_clr,
    input  logic              fill_start,
    output logic              busy
);

    // One extra bit so that DEPTH == 2**ADDR_W is still representable.
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE,
        FILL
    } fill_state_t;

    fill_state_t       state, state_next;
    logic [ADDR_W-1:0] cnt, cnt_next;
    logic              fill_we;

    // The array is never reset; it powers up holding INIT_VAL everywhere.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: INIT_VAL};

    logic wr_in_range;
    logic rd_in_range;
    logic wr_ok;
    logic rd_ok;
    logic err_new;

    logic [DATA_W-1:0] s1_data;
    logic              s1_valid;

    assign busy        = (state == FILL);
    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_X);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_X);

    // User requests only count while the fill engine is idle.
    assign wr_ok   = !busy && wr_en && wr_in_range;
    assign rd_ok   = !busy && rd_en && rd_in_range;
    assign err_new = !busy && ((wr_en && !wr_in_range) || (rd_en && !rd_in_range));

    // Fill state and counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Fill next-state logic: walk cnt from 0 to DEPTH-1, one word per cycle,
    // then return to IDLE so busy lasts exactly DEPTH cycles.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        fill_we    = 1'b0;
        case (state)
            IDLE: begin
                if (fill_start) begin
                    state_next = FILL;
                    cnt_next   = '0;
                end
            end
            FILL: begin
                fill_we = 1'b1;
                if (cnt == LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Single write port shared by the fill engine and the user; they never
    // collide because user writes are blocked while busy.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            mem[cnt] <= INIT_VAL;
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // First read stage. Non-blocking semantics give read-first behaviour when
    // the same address is written on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_data  <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= rd_ok;
            if (rd_ok) begin
                s1_data <= mem[rd_addr];
            end
        end
    end

    // Sticky error flag; a fresh error outranks a clear on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_err <= 1'b0;
        end else if (err_new) begin
            addr_err <= 1'b1;
        end else if (err_clr) begin
            addr_err <= 1'b0;
        end
    end

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] s2_data;
            logic              s2_valid;

            // Optional output stage; data only moves on a valid beat so the
            // output holds between reads.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_data  <= '0;
                    s2_valid <= 1'b0;
                end else begin
                    s2_valid <= s1_valid;
                    if (s1_valid) begin
                        s2_data <= s1_data;
                    end
                end
            end

            assign data_out  = s2_data;
            assign valid_out = s2_valid;
        end else begin : g_lat1
            assign data_out  = s1_data;
            assign valid_out = s1_valid;
        end
    endgenerate

endmodule

// File: tb/tb_bram_rw_fill.sv
// -----------------------------------------------------------------------------
// tb_bram_rw_fill
//
// Directed testbench for bram_rw_fill. Instance "dut" uses the default
// parameters (8-bit x 9 words, latency 1); instance "dut_b" uses a 16-bit x 32
// word configuration with latency 2. Inputs change 1 ns after the rising edge
// and outputs are sampled there too, so every check sees the state left by the
// preceding edge.
// -----------------------------------------------------------------------------
module tb_bram_rw_fill;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       wr_en, rd_en, err_clr, fill_start;
    logic [3:0] wr_addr, rd_addr;
    logic [7:0] wr_data;
    logic [7:0] data_out;
    logic       valid_out, addr_err, busy;

    logic        wr_en_b, rd_en_b, err_clr_b, fill_start_b;
    logic [4:0]  wr_addr_b, rd_addr_b;
    logic [15:0] wr_data_b;
    logic [15:0] data_out_b;
    logic        valid_out_b, addr_err_b, busy_b;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    bram_rw_fill dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .addr_err   (addr_err),
        .err_clr    (err_clr),
        .fill_start (fill_start),
        .busy       (busy)
    );

    bram_rw_fill #(
        .DATA_W   (16),
        .DEPTH    (32),
        .ADDR_W   (5),
        .INIT_VAL (16'h0001),
        .READ_LAT (2)
    ) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en_b),
        .wr_addr    (wr_addr_b),
        .wr_data    (wr_data_b),
        .rd_en      (rd_en_b),
        .rd_addr    (rd_addr_b),
        .data_out   (data_out_b),
        .valid_out  (valid_out_b),
        .addr_err   (addr_err_b),
        .err_clr    (err_clr_b),
        .fill_start (fill_start_b),
        .busy       (busy_b)
    );

    // Count one comparison and report it if the observed value is wrong.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Wait for the next rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of inputs to the default instance and clock it in.
    task automatic applyStimulus(input logic we, input logic [3:0] wa,
                                 input logic [7:0] wd, input logic re,
                                 input logic [3:0] ra, input logic ec,
                                 input logic fs);
        wr_en      = we;
        wr_addr    = wa;
        wr_data    = wd;
        rd_en      = re;
        rd_addr    = ra;
        err_clr    = ec;
        fill_start = fs;
        tick();
    endtask

    initial begin
        int  busy_cycles;
        logic saw_valid;

        rst_n = 1'b0;
        wr_en = 0; rd_en = 0; err_clr = 0; fill_start = 0;
        wr_addr = 0; rd_addr = 0; wr_data = 0;
        wr_en_b = 0; rd_en_b = 0; err_clr_b = 0; fill_start_b = 0;
        wr_addr_b = 0; rd_addr_b = 0; wr_data_b = 0;

        #12;
        checkOutput("rst_data_out", 32'(data_out), 32'h0);
        checkOutput("rst_valid", 32'(valid_out), 32'h0);
        checkOutput("rst_addr_err", 32'(addr_err), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_b_valid", 32'(valid_out_b), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Power-up contents: nine back-to-back reads, each valid right after its edge.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(0, 0, 0, 1, 4'(i), 0, 0);
            checkOutput($sformatf("init_valid_%0d", i), 32'(valid_out), 32'h1);
            checkOutput($sformatf("init_data_%0d", i), 32'(data_out), 32'h01);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("valid_drops", 32'(valid_out), 32'h0);
        checkOutput("data_holds", 32'(data_out), 32'h01);

        // Simple write then read, then same-edge write/read (read-first).
        applyStimulus(1, 3, 8'hA5, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 3, 0, 0);
        checkOutput("wr_rd_a5", 32'(data_out), 32'hA5);
        applyStimulus(1, 3, 8'h5A, 1, 3, 0, 0);
        checkOutput("read_first_old", 32'(data_out), 32'hA5);
        checkOutput("read_first_valid", 32'(valid_out), 32'h1);
        applyStimulus(0, 0, 0, 1, 3, 0, 0);
        checkOutput("read_after_5a", 32'(data_out), 32'h5A);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // Out-of-range accesses and the sticky error flag.
        applyStimulus(0, 0, 0, 1, 9, 0, 0);
        checkOutput("oor_rd_valid", 32'(valid_out), 32'h0);
        checkOutput("oor_rd_data", 32'(data_out), 32'h5A);
        checkOutput("oor_rd_err", 32'(addr_err), 32'h1);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkOutput("err_clr", 32'(addr_err), 32'h0);
        applyStimulus(1, 15, 8'h77, 0, 0, 0, 0);
        checkOutput("oor_wr_err", 32'(addr_err), 32'h1);
        checkOutput("oor_wr_valid", 32'(valid_out), 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkOutput("err_clr_2", 32'(addr_err), 32'h0);
        applyStimulus(0, 0, 0, 1, 12, 1, 0);
        checkOutput("err_wins_clr", 32'(addr_err), 32'h1);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkOutput("err_clr_3", 32'(addr_err), 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // Full fill: preload 0xFF, start fill together with a read of word 0.
        for (int i = 0; i < 9; i++) applyStimulus(1, 4'(i), 8'hFF, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 1);
        checkOutput("fill_same_edge_valid", 32'(valid_out), 32'h1);
        checkOutput("fill_same_edge_data", 32'(data_out), 32'hFF);
        checkOutput("fill_busy_rise", 32'(busy), 32'h1);

        // While busy, alternate legal and illegal reads plus writes; none may act.
        busy_cycles = 0;
        saw_valid   = 1'b0;
        for (int k = 0; k < 40 && busy; k++) begin
            busy_cycles++;
            applyStimulus(1, 4'(k % 9), 8'h33, 1, (k % 2 == 0) ? 4'(k % 9) : 4'd12, 0, 0);
            if (valid_out) saw_valid = 1'b1;
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("fill_busy_cycles", 32'(busy_cycles), 32'd9);
        checkOutput("fill_no_valid", 32'(saw_valid), 32'h0);
        checkOutput("fill_no_err", 32'(addr_err), 32'h0);
        checkOutput("fill_busy_fall", 32'(busy), 32'h0);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(0, 0, 0, 1, 4'(i), 0, 0);
            checkOutput($sformatf("filled_%0d", i), 32'(data_out), 32'h01);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // Reset in the middle of a fill: words 0..3 written, 4..8 untouched.
        for (int i = 0; i < 9; i++) applyStimulus(1, 4'(i), 8'hFF, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("midfill_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("midfill_reset_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("no_restart", 32'(busy), 32'h0);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(0, 0, 0, 1, 4'(i), 0, 0);
            checkOutput($sformatf("partial_%0d", i), 32'(data_out), (i < 4) ? 32'h01 : 32'hFF);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // Second configuration: 16-bit, 32 words, two-cycle read latency.
        wr_en_b = 1; wr_addr_b = 5'd31; wr_data_b = 16'hBEEF;
        tick();
        wr_en_b = 0; rd_en_b = 1; rd_addr_b = 5'd31;
        tick();
        rd_en_b = 0;
        checkOutput("b_lat_not_yet", 32'(valid_out_b), 32'h0);
        tick();
        checkOutput("b_lat2_valid", 32'(valid_out_b), 32'h1);
        checkOutput("b_lat2_data", 32'(data_out_b), 32'hBEEF);
        tick();
        checkOutput("b_valid_pulse", 32'(valid_out_b), 32'h0);
        checkOutput("b_data_holds", 32'(data_out_b), 32'hBEEF);
        checkOutput("b_addr_err", 32'(addr_err_b), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
